// File: rtl/multi_tick_gen_pkg.sv
// Shared constants, mode encoding and width helper for the multi-channel tick generator.
package multi_tick_gen_pkg;

    localparam int DIV_WIDTH_DEF   = 16;
    localparam int DEFAULT_DIV_DEF = 128;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } tick_mode_e;

    // ceil(log2(n)) but never less than 1, so a single-channel select is still a real port.
    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(n)) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/multi_tick_gen_ch.sv
// One tick channel: shadow config, active mode, down-counter and registered tick/clk_div/busy.
module tick_gen_ch
    import multi_tick_gen_pkg::*;
#(
    parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_restart,
    input  logic                 i_cfg_we,
    input  logic [DIV_WIDTH-1:0] i_cfg_div,
    input  logic                 i_cfg_oneshot,
    output logic                 o_tick,
    output logic                 o_clk_div,
    output logic                 o_busy
);

    localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] r_sh_div;
    tick_mode_e           r_sh_mode;
    tick_mode_e           r_act_mode;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_en_q;
    logic                 r_parked;
    logic                 r_tick;
    logic                 r_clk_div;
    logic                 r_busy;

    logic [DIV_WIDTH-1:0] w_sh_div_nxt;
    tick_mode_e           w_sh_mode_nxt;
    logic [DIV_WIDTH-1:0] w_reload_val;
    logic [DIV_WIDTH-1:0] w_cnt_eff;
    logic [DIV_WIDTH-1:0] w_cnt_dec;
    tick_mode_e           w_mode_cur;
    logic                 w_rise;
    logic                 w_restart;
    logic                 w_load;
    logic                 w_active;
    logic                 w_term;
    logic                 w_park;

    // A write in the same cycle as a reload is seen by that reload.
    assign w_sh_div_nxt  = i_cfg_we ? i_cfg_div : r_sh_div;
    assign w_sh_mode_nxt = i_cfg_we ? (i_cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC) : r_sh_mode;
    assign w_reload_val  = (w_sh_div_nxt == '0) ? '0 : (w_sh_div_nxt - ONE);

    assign w_rise    = i_en & ~r_en_q;
    assign w_restart = i_en & i_restart;
    assign w_load    = w_rise | w_restart;
    assign w_active  = i_en & (w_load | ~r_parked);

    // Enable rise / restart count the current cycle as the first of the new period,
    // so the first tick lands exactly D cycles later and a restart hides a pending terminal count.
    assign w_cnt_eff  = w_load ? w_reload_val : r_cnt;
    assign w_cnt_dec  = w_cnt_eff - ONE;
    assign w_term     = w_active & (w_cnt_eff == '0);
    assign w_mode_cur = w_load ? w_sh_mode_nxt : r_act_mode;
    assign w_park     = w_term & (w_mode_cur == MODE_ONESHOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_div   <= RST_DIV;
            r_sh_mode  <= MODE_PERIODIC;
            r_act_mode <= MODE_PERIODIC;
            r_cnt      <= RST_DIV - ONE;
            r_en_q     <= 1'b0;
            r_parked   <= 1'b0;
            r_tick     <= 1'b0;
            r_clk_div  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_en_q    <= i_en;
            r_sh_div  <= w_sh_div_nxt;
            r_sh_mode <= w_sh_mode_nxt;
            if (!i_en) begin
                r_tick     <= 1'b0;
                r_busy     <= 1'b0;
                r_clk_div  <= 1'b0;
                r_act_mode <= w_sh_mode_nxt;
            end else if (w_active) begin
                r_tick    <= w_term;
                r_busy    <= ~w_park;
                r_clk_div <= (w_restart ? 1'b0 : r_clk_div) ^ w_term;
                r_cnt     <= w_term ? w_reload_val : w_cnt_dec;
                r_parked  <= w_park;
                if (w_load || w_term) r_act_mode <= w_sh_mode_nxt;
            end else begin
                r_tick <= 1'b0;
                r_busy <= 1'b0;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_div = r_clk_div;
    assign o_busy    = r_busy;

endmodule

// File: rtl/multi_tick_gen.sv
// NUM_CH independent programmable tick / divided-clock channels sharing one config write port.
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH-1:0]               ch_en,
    input  logic [NUM_CH-1:0]               restart,
    input  logic                            cfg_we,
    input  logic [clog2_safe(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_WIDTH-1:0]            cfg_div,
    input  logic                            cfg_oneshot,
    output logic [NUM_CH-1:0]               tick,
    output logic [NUM_CH-1:0]               clk_div,
    output logic [NUM_CH-1:0]               busy
);

    localparam int CH_W = clog2_safe(NUM_CH);

    logic [NUM_CH-1:0] w_we;

    // Addresses at or beyond NUM_CH match no channel and are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_we[g] = cfg_we && (cfg_ch == CH_W'(g));

        tick_gen_ch #(
            .DIV_WIDTH   (DIV_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_en          (ch_en[g]),
            .i_restart     (restart[g]),
            .i_cfg_we      (w_we[g]),
            .i_cfg_div     (cfg_div),
            .i_cfg_oneshot (cfg_oneshot),
            .o_tick        (tick[g]),
            .o_clk_div     (clk_div[g]),
            .o_busy        (busy[g])
        );
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen: vector table for short corner cases plus long hand-written sequences.
module tb_multi_tick_gen;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ch_en;
    logic [3:0]  restart;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_oneshot;
    logic [3:0]  tick;
    logic [3:0]  clk_div;
    logic [3:0]  busy;

    // Second instance with 3 channels so an out-of-range cfg_ch is encodable.
    logic [2:0]  b_en;
    logic [2:0]  b_restart;
    logic        b_we;
    logic [1:0]  b_ch;
    logic [7:0]  b_div;
    logic        b_os;
    logic [2:0]  b_tick;
    logic [2:0]  b_clk_div;
    logic [2:0]  b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    multi_tick_gen dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .restart(restart),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
        .tick(tick), .clk_div(clk_div), .busy(busy)
    );

    multi_tick_gen #(.NUM_CH(3), .DIV_WIDTH(8), .DEFAULT_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ch_en(b_en), .restart(b_restart),
        .cfg_we(b_we), .cfg_ch(b_ch), .cfg_div(b_div), .cfg_oneshot(b_os),
        .tick(b_tick), .clk_div(b_clk_div), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  en;
        logic [3:0]  rs;
        logic        we;
        logic [1:0]  ch;
        logic [15:0] div;
        logic        os;
        logic [3:0]  e_tick;
        logic [3:0]  e_clk;
        logic [3:0]  e_busy;
    } vec_t;

    vec_t tbl [24];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int first_k;

        rst_n = 1'b0; ch_en = '0; restart = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
        b_en = '0; b_restart = '0; b_we = 1'b0; b_ch = '0; b_div = '0; b_os = 1'b0;

        // Restart-at-terminal, D=0/1/3 periodic, disable, one-shot re-arm on ch3.
        //            en    rs    we    ch    div     os    tick  clk   busy
        tbl[0]  = '{4'h0, 4'h0, 1'b1, 2'd3, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h8};
        tbl[2]  = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h0, 4'h8};
        tbl[3]  = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h8};
        tbl[4]  = '{4'h8, 4'h0, 1'b1, 2'd3, 16'd3, 1'b0, 4'h8, 4'h0, 4'h8};
        tbl[5]  = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h8};
        tbl[6]  = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h8};
        tbl[7]  = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h8};
        tbl[8]  = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h8, 4'h8};
        tbl[9]  = '{4'h8, 4'h8, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h8};
        tbl[10] = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h8};
        tbl[11] = '{4'h8, 4'h8, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h8};
        tbl[12] = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h8};
        tbl[13] = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h8};
        tbl[14] = '{4'h0, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[15] = '{4'h0, 4'h0, 1'b1, 2'd3, 16'd2, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[16] = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h8};
        tbl[17] = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h0};
        tbl[18] = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h8, 4'h0};
        tbl[19] = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h8, 4'h0};
        tbl[20] = '{4'h8, 4'h8, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h8};
        tbl[21] = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h8, 4'h8, 4'h0};
        tbl[22] = '{4'h8, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h8, 4'h0};
        tbl[23] = '{4'h0, 4'h0, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0};

        // Reset values
        repeat (3) step();
        check("rst tick", 32'(tick), 32'h0);
        check("rst clk_div", 32'(clk_div), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();
        check("idle busy", 32'(busy), 32'h0);

        // Default D=128 periodic on ch0
        ch_en = 4'h1;
        for (int k = 1; k <= 400; k++) begin
            step();
            check($sformatf("t1 tick k=%0d", k), 32'(tick[0]), 32'((k % 128) == 0));
            check($sformatf("t1 clk_div k=%0d", k), 32'(clk_div[0]), 32'((k / 128) % 2));
            check($sformatf("t1 busy k=%0d", k), 32'(busy[0]), 32'h1);
        end

        // Mid-period divisor change on ch1
        ch_en = 4'h2;
        for (int k = 1; k <= 145; k++) begin
            step();
            check($sformatf("t2 tick k=%0d", k), 32'(tick[1]),
                  32'((k == 128) || (k > 128 && ((k - 128) % 5) == 0)));
            cfg_we = 1'b0;
            if (k == 50) begin
                cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5; cfg_oneshot = 1'b0;
            end
        end
        cfg_we = 1'b0;

        // One-shot D=10 on ch2, then restart re-arms
        ch_en = 4'h4;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd10; cfg_oneshot = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            step();
            cfg_we = 1'b0;
            check($sformatf("t3 tick k=%0d", k), 32'(tick[2]), 32'(k == 10));
            check($sformatf("t3 busy k=%0d", k), 32'(busy[2]), 32'(k < 10));
        end
        restart = 4'h4;
        for (int k = 1; k <= 12; k++) begin
            step();
            restart = 4'h0;
            check($sformatf("t3r tick k=%0d", k), 32'(tick[2]), 32'(k == 10));
        end

        // D=0 then D=1 on ch3: tick every cycle, clk_div toggles every cycle
        ch_en = 4'h8;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd0; cfg_oneshot = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            cfg_we = 1'b0;
            check($sformatf("t4 tick k=%0d", k), 32'(tick[3]), 32'h1);
            check($sformatf("t4 clk_div k=%0d", k), 32'(clk_div[3]), 32'(k % 2));
            if (k == 8) begin
                cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd1; cfg_oneshot = 1'b0;
            end
        end

        // Maximum divisor: first tick exactly 65535 cycles after enable
        ch_en = 4'h0;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'hFFFF; cfg_oneshot = 1'b0;
        step();
        cfg_we = 1'b0;
        ch_en = 4'h8;
        first_k = -1;
        for (int k = 1; k <= 65540; k++) begin
            step();
            if (tick[3] === 1'b1) begin
                first_k = k;
                break;
            end
        end
        check("t4 max first tick", 32'(first_k), 32'd65535);
        check("t4 max busy", 32'(busy[3]), 32'h1);

        // Vector table
        for (int i = 0; i < 24; i++) begin
            ch_en = tbl[i].en; restart = tbl[i].rs; cfg_we = tbl[i].we;
            cfg_ch = tbl[i].ch; cfg_div = tbl[i].div; cfg_oneshot = tbl[i].os;
            step();
            check($sformatf("vec%0d tick", i), 32'(tick), 32'(tbl[i].e_tick));
            check($sformatf("vec%0d clk_div", i), 32'(clk_div), 32'(tbl[i].e_clk));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end
        restart = '0; cfg_we = 1'b0;

        // All channels running, then asynchronous reset mid-count
        ch_en = 4'hF;
        repeat (5) step();
        check("t6 pre tick", 32'(tick), 32'h2);
        check("t6 pre clk_div", 32'(clk_div), 32'hA);
        check("t6 pre busy", 32'(busy), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async tick", 32'(tick), 32'h0);
        check("t6 async clk_div", 32'(clk_div), 32'h0);
        check("t6 async busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            step();
            check($sformatf("t6 tick k=%0d", k), 32'(tick), ((k % 128) == 0) ? 32'hF : 32'h0);
            check($sformatf("t6 busy k=%0d", k), 32'(busy), 32'hF);
            if (k == 128) check("t6 clk_div k=128", 32'(clk_div), 32'hF);
        end
        ch_en = 4'h0;

        // 3-channel instance: cfg_ch=3 write ignored, cfg_ch=2 write applied
        b_we = 1'b1; b_ch = 2'd3; b_div = 8'd1; b_os = 1'b0;
        step();
        b_ch = 2'd2; b_div = 8'd2;
        step();
        b_we = 1'b0;
        b_en = 3'h7;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("b tick k=%0d", k), 32'(b_tick),
                  32'({(k % 2) == 0, (k % 4) == 0, (k % 4) == 0}));
            check($sformatf("b busy k=%0d", k), 32'(b_busy), 32'h7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
